// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch resolution unit.
//
// The front end fetches predict-not-taken. When execute resolves a taken branch
// this block latches the target, offers it to fetch over a valid/ready handshake
// and keeps execute stalled until fetch accepts it. After acceptance it holds
// flush for FLUSH_CYCLES more cycles so that wrong-path instructions already in
// IF/ID and ID/EX are squashed. All outputs are driven from registers.
//
// Optional feature: define BRANCH_STATS_EN to add the br_count/taken_count
// statistics counters and their output ports.
//
// Parameters:
//   FLUSH_CYCLES  flush cycles after fetch accepts the redirect (1..15)
//   PC_W          width of PC/target values
//
// Ports:
//   clock           system clock, rising edge
//   reset_n         asynchronous active-low reset
//   ex_valid        execute holds a valid instruction
//   ex_isBranch     instruction is a branch or jump
//   ex_brType       00 BNE, 01 BLT, 10 JUMP, 11 reserved (never taken)
//   isNE            ALU not-equal flag
//   isLessThan      ALU less-than flag
//   ex_target       branch target computed in execute
//   redirect_ready  fetch accepts the redirect this cycle
//   redirect_valid  redirect request to fetch
//   redirect_pc     new fetch PC, stable while redirect_valid is high
//   flush           squash IF/ID and ID/EX
//   stall_ex        hold the execute stage
//   taken_pulse     one-cycle pulse the cycle after a taken branch resolves
//   br_count        (BRANCH_STATS_EN) branches seen in IDLE, types 00..10
//   taken_count     (BRANCH_STATS_EN) taken branches accepted in IDLE
module branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned PC_W         = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            ex_valid,
  input  logic            ex_isBranch,
  input  logic [1:0]      ex_brType,
  input  logic            isNE,
  input  logic            isLessThan,
  input  logic [PC_W-1:0] ex_target,
  input  logic            redirect_ready,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic            stall_ex,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     br_count,
  output logic [31:0]     taken_count,
`endif
  output logic            taken_pulse
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRedirect = 2'd1,
    StFlush    = 2'd2
  } state_e;

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] redirectPc_q, redirectPc_d;
  logic [3:0]      flushCnt_q, flushCnt_d;
  logic            takenPulse_q, takenPulse_d;

  logic taken;
  logic resolve;

  always_comb begin
    taken = 1'b0;
    case (ex_brType)
      2'b00:   taken = isNE;
      2'b01:   taken = isLessThan;
      2'b10:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign resolve = ex_valid & ex_isBranch & taken;

  always_comb begin
    state_d      = state_q;
    redirectPc_d = redirectPc_q;
    flushCnt_d   = flushCnt_q;
    takenPulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (resolve) begin
          redirectPc_d = ex_target;
          takenPulse_d = 1'b1;
          state_d      = StRedirect;
        end
      end
      StRedirect: begin
        // Execute inputs are wrong-path here; only the handshake matters.
        if (redirect_ready) begin
          redirectPc_d = '0;
          flushCnt_d   = FlushLoad;
          state_d      = StFlush;
        end
      end
      StFlush: begin
        if (flushCnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          flushCnt_d = flushCnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      redirectPc_q <= '0;
      flushCnt_q   <= '0;
      takenPulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      redirectPc_q <= redirectPc_d;
      flushCnt_q   <= flushCnt_d;
      takenPulse_q <= takenPulse_d;
    end
  end

  // Outputs decode the state register only, so nothing combinational reaches them.
  assign redirect_valid = (state_q == StRedirect);
  assign stall_ex       = (state_q == StRedirect);
  assign flush          = (state_q != StIdle);
  assign redirect_pc    = redirectPc_q;
  assign taken_pulse    = takenPulse_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] brCount_q;
  logic [31:0] takenCount_q;
  logic        countBranch;

  assign countBranch = (state_q == StIdle) & ex_valid & ex_isBranch & (ex_brType != 2'b11);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      brCount_q    <= '0;
      takenCount_q <= '0;
    end else begin
      if (countBranch) begin
        brCount_q <= brCount_q + 32'd1;
      end
      if ((state_q == StIdle) && resolve) begin
        takenCount_q <= takenCount_q + 32'd1;
      end
    end
  end

  assign br_count    = brCount_q;
  assign taken_count = takenCount_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  localparam int unsigned PcW = 32;

  logic           clock;
  logic           reset_n;
  logic           ex_valid;
  logic           ex_isBranch;
  logic [1:0]     ex_brType;
  logic           isNE;
  logic           isLessThan;
  logic [PcW-1:0] ex_target;
  logic           redirect_ready;
  logic           redirect_valid;
  logic [PcW-1:0] redirect_pc;
  logic           flush;
  logic           stall_ex;
  logic           taken_pulse;
`ifdef BRANCH_STATS_EN
  logic [31:0]    br_count;
  logic [31:0]    taken_count;
`endif

  int nCmp;
  int nBad;

  // {redirect_valid, flush, stall_ex, taken_pulse}
  logic [3:0] outs;
  assign outs = {redirect_valid, flush, stall_ex, taken_pulse};

  branch_resolve #(
    .FLUSH_CYCLES(2),
    .PC_W        (PcW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ex_valid      (ex_valid),
    .ex_isBranch   (ex_isBranch),
    .ex_brType     (ex_brType),
    .isNE          (isNE),
    .isLessThan    (isLessThan),
    .ex_target     (ex_target),
    .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
    .stall_ex      (stall_ex),
`ifdef BRANCH_STATS_EN
    .br_count      (br_count),
    .taken_count   (taken_count),
`endif
    .taken_pulse   (taken_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    ex_valid       = 1'b0;
    ex_isBranch    = 1'b0;
    ex_brType      = 2'b00;
    isNE           = 1'b0;
    isLessThan     = 1'b0;
    ex_target      = '0;
    redirect_ready = 1'b0;
  endtask

  task automatic drive(input logic [1:0] ty, input logic ne, input logic lt,
                       input logic [PcW-1:0] tgt);
    ex_valid    = 1'b1;
    ex_isBranch = 1'b1;
    ex_brType   = ty;
    isNE        = ne;
    isLessThan  = lt;
    ex_target   = tgt;
  endtask

  task automatic test_reset();
    clearInputs();
    reset_n = 1'b0;
    #12;
    nCmp++;
    if (outs !== 4'b0000 || redirect_pc !== 32'h0) begin
      nBad++;
      $display("FAIL reset_init outs=%b pc=%h exp outs=0000 pc=0", outs, redirect_pc);
    end
    @(negedge clock);
    reset_n = 1'b1;
    step();
    // Enter REDIRECT with fetch stalled, then reset asynchronously.
    drive(2'b10, 1'b0, 1'b0, 32'h0000_0ABC);
    step();
    clearInputs();
    nCmp++;
    if (outs !== 4'b1111 || redirect_pc !== 32'h0000_0ABC) begin
      nBad++;
      $display("FAIL reset_pre outs=%b pc=%h exp outs=1111 pc=00000abc", outs, redirect_pc);
    end
    #2;
    reset_n = 1'b0;
    #1;
    nCmp++;
    if (outs !== 4'b0000 || redirect_pc !== 32'h0) begin
      nBad++;
      $display("FAIL reset_async outs=%b pc=%h exp outs=0000 pc=0", outs, redirect_pc);
    end
    step();
    reset_n = 1'b1;
    step();
    nCmp++;
    if (outs !== 4'b0000) begin
      nBad++;
      $display("FAIL reset_idle outs=%b exp 0000", outs);
    end
  endtask

  task automatic test_bne_taken();
    drive(2'b00, 1'b1, 1'b0, 32'h0000_0040);
    redirect_ready = 1'b1;
    step();
    clearInputs();
    redirect_ready = 1'b1;
    nCmp++;
    if (outs !== 4'b1111 || redirect_pc !== 32'h0000_0040) begin
      nBad++;
      $display("FAIL bne_c1 outs=%b pc=%h exp outs=1111 pc=00000040", outs, redirect_pc);
    end
    step();
    nCmp++;
    if (outs !== 4'b0100) begin
      nBad++;
      $display("FAIL bne_c2 outs=%b exp 0100", outs);
    end
    step();
    nCmp++;
    if (outs !== 4'b0100) begin
      nBad++;
      $display("FAIL bne_c3 outs=%b exp 0100", outs);
    end
    step();
    nCmp++;
    if (outs !== 4'b0000) begin
      nBad++;
      $display("FAIL bne_c4 outs=%b exp 0000", outs);
    end
    clearInputs();
  endtask

  task automatic test_not_taken();
    logic [1:0] tys [4];
    logic       nes [4];
    logic       lts [4];
    logic       isb [4];
    tys = '{2'b00, 2'b01, 2'b11, 2'b10};
    nes = '{1'b0, 1'b1, 1'b1, 1'b1};
    lts = '{1'b1, 1'b0, 1'b1, 1'b1};
    isb = '{1'b1, 1'b1, 1'b1, 1'b0};  // last: jump encoding but not a branch
    for (int i = 0; i < 4; i++) begin
      drive(tys[i], nes[i], lts[i], 32'h0000_0500 + 32'(i));
      ex_isBranch    = isb[i];
      redirect_ready = 1'b1;
      step();
      nCmp++;
      if (outs !== 4'b0000) begin
        nBad++;
        $display("FAIL not_taken_%0d outs=%b exp 0000", i, outs);
      end
    end
    clearInputs();
    step();
    nCmp++;
    if (outs !== 4'b0000) begin
      nBad++;
      $display("FAIL not_taken_after outs=%b exp 0000", outs);
    end
  endtask

  task automatic test_backpressure();
    drive(2'b10, 1'b0, 1'b0, 32'h0000_1234);
    redirect_ready = 1'b0;
    step();
    // Wrong-path BNE that would be taken if it were looked at.
    drive(2'b00, 1'b1, 1'b0, 32'h0000_0099);
    nCmp++;
    if (outs !== 4'b1111 || redirect_pc !== 32'h0000_1234) begin
      nBad++;
      $display("FAIL bp_c1 outs=%b pc=%h exp outs=1111 pc=00001234", outs, redirect_pc);
    end
    for (int i = 2; i <= 6; i++) begin
      step();
      nCmp++;
      if (outs !== 4'b1110 || redirect_pc !== 32'h0000_1234) begin
        nBad++;
        $display("FAIL bp_c%0d outs=%b pc=%h exp outs=1110 pc=00001234", i, outs, redirect_pc);
      end
    end
    redirect_ready = 1'b1;
    step();
    nCmp++;
    if (outs !== 4'b0100) begin
      nBad++;
      $display("FAIL bp_accept outs=%b exp 0100", outs);
    end
    step();
    nCmp++;
    if (outs !== 4'b0100) begin
      nBad++;
      $display("FAIL bp_flush2 outs=%b exp 0100", outs);
    end
    clearInputs();
    step();
    nCmp++;
    if (outs !== 4'b0000) begin
      nBad++;
      $display("FAIL bp_idle outs=%b exp 0000", outs);
    end
  endtask

  task automatic test_back_to_back();
    drive(2'b01, 1'b0, 1'b1, 32'h0000_0200);
    redirect_ready = 1'b1;
    step();
    clearInputs();
    redirect_ready = 1'b1;
    nCmp++;
    if (outs !== 4'b1111 || redirect_pc !== 32'h0000_0200) begin
      nBad++;
      $display("FAIL b2b_first outs=%b pc=%h exp outs=1111 pc=00000200", outs, redirect_pc);
    end
    step();
    drive(2'b01, 1'b0, 1'b1, 32'h0000_0300);
    step();
    nCmp++;
    if (outs !== 4'b0100) begin
      nBad++;
      $display("FAIL b2b_flush_ignore outs=%b exp 0100", outs);
    end
    step();
    nCmp++;
    if (outs !== 4'b0000) begin
      nBad++;
      $display("FAIL b2b_idle outs=%b exp 0000", outs);
    end
    step();
    clearInputs();
    redirect_ready = 1'b1;
    nCmp++;
    if (outs !== 4'b1111 || redirect_pc !== 32'h0000_0300) begin
      nBad++;
      $display("FAIL b2b_second outs=%b pc=%h exp outs=1111 pc=00000300", outs, redirect_pc);
    end
    step();
    step();
    step();
    nCmp++;
    if (outs !== 4'b0000) begin
      nBad++;
      $display("FAIL b2b_done outs=%b exp 0000", outs);
    end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    logic [1:0] tys [5];
    logic       nes [5];
    tys = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
    nes = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    // Pattern: JUMP taken, BNE taken, BNE not, BLT not, BNE taken.
    reset_n = 1'b0;
    clearInputs();
    step();
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      drive(tys[i], nes[i], 1'b0, 32'h0000_0700);
      redirect_ready = 1'b1;
      step();
      clearInputs();
      redirect_ready = 1'b1;
      for (int k = 0; k < 4; k++) step();
    end
    nCmp++;
    if (br_count !== 32'd5 || taken_count !== 32'd3) begin
      nBad++;
      $display("FAIL stats_count br=%0d taken=%0d exp br=5 taken=3", br_count, taken_count);
    end
    @(negedge clock);
    dut.takenCount_q = 32'hFFFF_FFFF;
    #1;
    drive(2'b10, 1'b0, 1'b0, 32'h0000_0800);
    step();
    clearInputs();
    redirect_ready = 1'b1;
    nCmp++;
    if (taken_count !== 32'h0) begin
      nBad++;
      $display("FAIL stats_wrap taken=%h exp 00000000", taken_count);
    end
    for (int k = 0; k < 4; k++) step();
  endtask
`endif

  initial begin
    nCmp = 0;
    nBad = 0;
    test_reset();
    test_bne_taken();
    test_not_taken();
    test_backpressure();
    test_back_to_back();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
